// File: rtl/dct_pkg.sv
// dct_pkg: shared definitions for the DCT transpose buffer.
//   DW_DEFAULT / N_DEFAULT : default coefficient width and block dimension
//   MODE_PASS / MODE_TRANSPOSE : encodings of the per-block output mode
//   lane_lsb()             : bit offset of a DW-wide lane inside a packed vector
package dct_pkg;

  localparam int DW_DEFAULT = 12;
  localparam int N_DEFAULT  = 8;

  localparam logic MODE_PASS      = 1'b0;
  localparam logic MODE_TRANSPOSE = 1'b1;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pp_bank.sv
// pp_bank: one N x N register bank of the ping-pong transpose buffer.
//   clk, rst : clock and asynchronous active-high reset
//   wr_en    : store wr_data into row wr_row this cycle
//   wr_row   : row being written
//   wr_data  : one row, lane c = column c
//   wr_mode  : block mode, latched when row 0 is written
//   rel      : the reader has consumed the whole block; clear full
//   rd_idx   : column (transpose) or row (pass-through) to present
//   full     : bank holds a complete block awaiting readout
//   rd_data  : selected column (lane r = row r) or row (lane c = column c)
module pp_bank
  import dct_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int N  = N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [N*DW-1:0]       wr_data,
  input  logic                  wr_mode,
  input  logic                  rel,
  input  logic [$clog2(N)-1:0]  rd_idx,
  output logic                  full,
  output logic [N*DW-1:0]       rd_data
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [DW-1:0] mem [N][N];
  logic          bank_mode;

  // Row write port; contents cleared on reset so out_vec reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][c] <= wr_data[lane_lsb(c, DW) +: DW];
      end
    end
  end

  // Full flag and per-block mode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      bank_mode <= MODE_PASS;
    end else begin
      // A bank is never written while full, so set and release never coincide.
      if (wr_en && (wr_row == LAST)) begin
        full <= 1'b1;
      end else if (rel) begin
        full <= 1'b0;
      end
      if (wr_en && (wr_row == '0)) begin
        bank_mode <= wr_mode;
      end
    end
  end

  // Read mux: column-out in transpose mode, row-out in pass-through mode.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      if (bank_mode == MODE_TRANSPOSE) begin
        rd_data[lane_lsb(k, DW) +: DW] = mem[k][rd_idx];
      end else begin
        rd_data[lane_lsb(k, DW) +: DW] = mem[rd_idx][k];
      end
    end
  end

endmodule

// File: rtl/dct_transpose_pp.sv
// dct_transpose_pp: ping-pong transpose buffer between the row and column
// DCT passes. Rows go in, columns (or rows in pass-through) come out; two
// banks let one block be written while the previous one is read.
//   sys_clk, sys_rst     : clock and asynchronous active-high reset
//   mode                 : 1 transpose, 0 pass-through; taken at each block's row 0
//   in_valid/in_ready    : input row handshake, in_row lane c = column c
//   out_valid/out_ready  : output vector handshake
//   out_vec              : column (lane r = row r) or row (lane c = column c)
//   out_first/out_last   : first / last vector of a block, qualified by out_valid
module dct_transpose_pp
  import dct_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int N  = N_DEFAULT
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_vec,
  output logic            out_first,
  output logic            out_last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic            wr_bank;
  logic            rd_bank;
  logic [CW-1:0]   wr_row;
  logic [CW-1:0]   rd_idx;
  logic [1:0]      full;
  logic [1:0]      wr_en;
  logic [1:0]      rel;
  logic [N*DW-1:0] rd_data [2];
  logic            accept;
  logic            xfer;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_bank #(
      .DW (DW),
      .N  (N)
    ) u_bank (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .wr_en   (wr_en[b]),
      .wr_row  (wr_row),
      .wr_data (in_row),
      .wr_mode (mode),
      .rel     (rel[b]),
      .rd_idx  (rd_idx),
      .full    (full[b]),
      .rd_data (rd_data[b])
    );
  end

  // Handshakes, bank steering and output framing.
  always_comb begin
    in_ready  = ~full[wr_bank];
    out_valid = full[rd_bank];
    accept    = in_valid & in_ready;
    xfer      = out_valid & out_ready;
    wr_en     = 2'b00;
    rel       = 2'b00;
    wr_en[wr_bank] = accept;
    rel[rd_bank]   = xfer & (rd_idx == LAST);
    out_vec   = rd_data[rd_bank];
    out_first = out_valid & (rd_idx == '0);
    out_last  = out_valid & (rd_idx == LAST);
  end

  // Write and read pointers; each side flips banks after its Nth beat.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else begin
      if (accept) begin
        if (wr_row == LAST) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + CW'(1);
        end
      end
      if (xfer) begin
        if (rd_idx == LAST) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_pp.sv
// tb_dct_transpose_pp: self-checking bench for dct_transpose_pp. A block-level
// reference model collects accepted rows, and when a block completes it queues
// the N vectors the block must produce; buffer occupancy (blocks held) gives
// the expected in_ready / out_valid.
module tb_dct_transpose_pp;

  localparam int DW = 12;
  localparam int N  = 8;
  localparam int VW = N * DW;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t vec;
    logic first;
    logic last;
  } ovec_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic mode;
  logic in_valid;
  logic in_ready;
  vec_t in_row;
  logic out_valid;
  logic out_ready;
  vec_t out_vec;
  logic out_first;
  logic out_last;

  int checks   = 0;
  int failures = 0;

  // reference model state
  vec_t  cur [N];
  int    cur_cnt;
  logic  cur_mode;
  int    held;
  int    rd_cnt;
  ovec_t exp_q[$];
  ovec_t exp_seen[$];
  ovec_t obs[$];
  int    ready_err;
  int    valid_err;
  int    timeouts;
  int    acc_total;
  int    tick_cnt;
  bit    rand_ready;

  dct_transpose_pp #(.DW(DW), .N(N)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic vec_t seq_row(input int base);
    vec_t v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  task automatic model_reset();
    cur_cnt = 0;
    held    = 0;
    rd_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic clear_log();
    obs.delete();
    exp_seen.delete();
    ready_err = 0;
    valid_err = 0;
    timeouts  = 0;
  endtask

  // Called at a falling edge; samples just before the next rising edge,
  // advances the model, and returns at the following falling edge.
  task automatic tick();
    bit    exp_ready;
    bit    exp_valid;
    ovec_t o;
    ovec_t e;
    #4;
    exp_ready = (held < 2);
    exp_valid = (held > 0);
    if (in_ready !== exp_ready) ready_err++;
    if (out_valid !== exp_valid) valid_err++;
    if (exp_valid && out_ready) begin
      o.vec = out_vec; o.first = out_first; o.last = out_last;
      obs.push_back(o);
      exp_seen.push_back(exp_q.pop_front());
      rd_cnt++;
      if (rd_cnt == N) begin
        rd_cnt = 0;
        held--;
      end
    end
    if (in_valid && exp_ready) begin
      if (cur_cnt == 0) cur_mode = mode;
      cur[cur_cnt] = in_row;
      cur_cnt++;
      acc_total++;
      if (cur_cnt == N) begin
        for (int i = 0; i < N; i++) begin
          e.vec = '0;
          for (int k = 0; k < N; k++)
            e.vec[k*DW +: DW] = cur_mode ? cur[k][i*DW +: DW] : cur[i][k*DW +: DW];
          e.first = (i == 0);
          e.last  = (i == N - 1);
          exp_q.push_back(e);
        end
        cur_cnt = 0;
        held++;
      end
    end
    tick_cnt++;
    @(negedge sys_clk);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_row(input vec_t row, input int gap);
    int start;
    int n;
    start = acc_total;
    n = 0;
    in_row   = row;
    in_valid = 1'b1;
    while (acc_total == start && n < 200) begin
      tick();
      n++;
    end
    if (acc_total == start) timeouts++;
    in_valid = 1'b0;
    in_row   = rand_vec();
    repeat (gap) tick();
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while (obs.size() < n && t < 500) begin
      tick();
      t++;
    end
    if (obs.size() < n) timeouts++;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_vec !== '0) begin failures++; $display("FAIL reset_out_vec: got %h want 0", out_vec); end
    checks++; if (out_first !== 1'b0) begin failures++; $display("FAIL reset_out_first: got %b want 0", out_first); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b want 0", out_last); end
  endtask

  task automatic test_transpose();
    vec_t want;
    clear_log();
    mode = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      send_row(seq_row(8 * r), 0);
      if (r == N - 2) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL transpose_early_valid: got %b want 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL transpose_latency: got %b want 1", out_valid); end
    drain(N);
    checks++; if (obs.size() != N) begin failures++; $display("FAIL transpose_count: got %0d want %0d", obs.size(), N); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== exp_seen[i].vec || obs[i].first !== exp_seen[i].first || obs[i].last !== exp_seen[i].last) begin
        failures++; $display("FAIL transpose_vec%0d: got %h f%b l%b want %h f%b l%b", i, obs[i].vec, obs[i].first, obs[i].last, exp_seen[i].vec, exp_seen[i].first, exp_seen[i].last);
      end
    end
    if (obs.size() == N) begin
      for (int r = 0; r < N; r++) want[r*DW +: DW] = DW'(8 * r);
      checks++; if (obs[0].vec !== want || obs[0].first !== 1'b1) begin failures++; $display("FAIL transpose_first: got %h f%b want %h f1", obs[0].vec, obs[0].first, want); end
      for (int r = 0; r < N; r++) want[r*DW +: DW] = DW'(8 * r + 7);
      checks++; if (obs[N-1].vec !== want || obs[N-1].last !== 1'b1) begin failures++; $display("FAIL transpose_last: got %h l%b want %h l1", obs[N-1].vec, obs[N-1].last, want); end
    end
    checks++; if (ready_err + valid_err + timeouts != 0) begin failures++; $display("FAIL transpose_handshake: got %0d/%0d/%0d want 0/0/0", ready_err, valid_err, timeouts); end
  endtask

  task automatic test_passthrough();
    clear_log();
    mode = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(seq_row(8 * r), 0);
    drain(N);
    checks++; if (obs.size() != N) begin failures++; $display("FAIL pass_count: got %0d want %0d", obs.size(), N); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== seq_row(8 * i) || obs[i].vec !== exp_seen[i].vec || obs[i].first !== exp_seen[i].first || obs[i].last !== exp_seen[i].last) begin
        failures++; $display("FAIL pass_vec%0d: got %h f%b l%b want %h", i, obs[i].vec, obs[i].first, obs[i].last, seq_row(8 * i));
      end
    end
    checks++; if (ready_err + valid_err + timeouts != 0) begin failures++; $display("FAIL pass_handshake: got %0d/%0d/%0d want 0/0/0", ready_err, valid_err, timeouts); end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_log();
    out_ready = 1'b1;
    t0 = tick_cnt;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < N; r++) begin
        if (r == 0) mode = 1'(b);
        send_row(seq_row(64 * b + 8 * r), 0);
      end
    end
    checks++; if (tick_cnt - t0 != 4 * N) begin failures++; $display("FAIL b2b_cycles: got %0d want %0d", tick_cnt - t0, 4 * N); end
    drain(4 * N);
    checks++; if (obs.size() != 4 * N) begin failures++; $display("FAIL b2b_count: got %0d want %0d", obs.size(), 4 * N); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== exp_seen[i].vec || obs[i].first !== exp_seen[i].first || obs[i].last !== exp_seen[i].last) begin
        failures++; $display("FAIL b2b_vec%0d: got %h want %h", i, obs[i].vec, exp_seen[i].vec);
      end
    end
    checks++; if (ready_err + valid_err + timeouts != 0) begin failures++; $display("FAIL b2b_handshake: got %0d/%0d/%0d want 0/0/0", ready_err, valid_err, timeouts); end
  endtask

  task automatic test_backpressure();
    clear_log();
    out_ready = 1'b0;
    for (int r = 0; r < 2 * N; r++) begin
      if (r % N == 0) mode = 1'($urandom_range(0, 1));
      send_row(rand_vec(), 0);
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
    in_row   = rand_vec();
    in_valid = 1'b1;
    repeat (5) tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_hold: got %b want 0", in_ready); end
    in_valid = 1'b0;
    drain(2 * N);
    checks++; if (obs.size() != 2 * N) begin failures++; $display("FAIL bp_count: got %0d want %0d", obs.size(), 2 * N); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== exp_seen[i].vec || obs[i].first !== exp_seen[i].first || obs[i].last !== exp_seen[i].last) begin
        failures++; $display("FAIL bp_vec%0d: got %h want %h", i, obs[i].vec, exp_seen[i].vec);
      end
    end
    checks++; if (ready_err + valid_err + timeouts != 0) begin failures++; $display("FAIL bp_handshake: got %0d/%0d/%0d want 0/0/0", ready_err, valid_err, timeouts); end
  endtask

  task automatic test_mode_gaps();
    clear_log();
    rand_ready = 1'b1;
    mode = 1'b1;
    for (int r = 0; r < N; r++) begin
      if (r == 3) mode = 1'b0;
      if (r == 5) mode = 1'b1;
      send_row(rand_vec(), 3);
    end
    mode = 1'b0;
    for (int r = 0; r < N; r++) begin
      if (r == 2) mode = 1'b1;
      send_row(rand_vec(), 3);
    end
    drain(2 * N);
    checks++; if (obs.size() != 2 * N) begin failures++; $display("FAIL gaps_count: got %0d want %0d", obs.size(), 2 * N); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== exp_seen[i].vec || obs[i].first !== exp_seen[i].first || obs[i].last !== exp_seen[i].last) begin
        failures++; $display("FAIL gaps_vec%0d: got %h want %h", i, obs[i].vec, exp_seen[i].vec);
      end
    end
    checks++; if (ready_err + valid_err + timeouts != 0) begin failures++; $display("FAIL gaps_handshake: got %0d/%0d/%0d want 0/0/0", ready_err, valid_err, timeouts); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    out_ready = 1'b0;
    mode = 1'b1;
    for (int r = 0; r < N; r++) send_row(rand_vec(), 0);
    drain(N - 3);
    out_ready = 1'b0;
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== exp_seen[i].vec) begin failures++; $display("FAIL rmid_prev_vec%0d: got %h want %h", i, obs[i].vec, exp_seen[i].vec); end
    end
    for (int r = 0; r < 5; r++) send_row(rand_vec(), 0);
    #1 sys_rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    checks++; if (out_vec !== '0) begin failures++; $display("FAIL rmid_out_vec: got %h want 0", out_vec); end
    model_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    clear_log();
    mode = 1'($urandom_range(0, 1));
    for (int r = 0; r < N; r++) send_row(rand_vec(), 0);
    drain(N);
    checks++; if (obs.size() != N) begin failures++; $display("FAIL rmid_count: got %0d want %0d", obs.size(), N); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].vec !== exp_seen[i].vec || obs[i].first !== exp_seen[i].first || obs[i].last !== exp_seen[i].last) begin
        failures++; $display("FAIL rmid_vec%0d: got %h f%b l%b want %h f%b l%b", i, obs[i].vec, obs[i].first, obs[i].last, exp_seen[i].vec, exp_seen[i].first, exp_seen[i].last);
      end
    end
    checks++; if (ready_err + valid_err + timeouts != 0) begin failures++; $display("FAIL rmid_handshake: got %0d/%0d/%0d want 0/0/0", ready_err, valid_err, timeouts); end
  endtask

  initial begin
    sys_rst    = 1'b1;
    mode       = 1'b0;
    in_valid   = 1'b0;
    in_row     = '0;
    out_ready  = 1'b0;
    rand_ready = 1'b0;
    acc_total  = 0;
    tick_cnt   = 0;
    model_reset();
    clear_log();
    repeat (2) @(negedge sys_clk);
    test_reset();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_transpose();
    test_passthrough();
    test_back_to_back();
    test_backpressure();
    test_mode_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
